// File: rtl/icnd2110_in_pkg.sv
// Shared ICND2110 framing constants and receiver state encoding.
// The transmitter side of the link builds its frames from the same values.
package icnd2110_defs;

  localparam int START_ONES      = 128;
  localparam int END_ONES        = 145;
  localparam int BLANK_BITS      = 16;
  localparam int WORD_BITS       = 16;
  localparam int WORDS_PER_GROUP = 6;
  localparam int GROUP_BITS      = WORD_BITS * WORDS_PER_GROUP;

  localparam int RUN_W     = 8;
  localparam int BIT_CNT_W = 7;
  localparam int IDX_W     = 3;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_BLANK  = 3'd1,
    ST_REG    = 3'd2,
    ST_GROUP  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // Ones-run counter saturates so that very long runs never alias to START_ONES.
  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] run);
    return (run == '1) ? run : run + RUN_W'(1);
  endfunction

endpackage

// File: rtl/icnd2110_bit_sampler.sv
// Brings the serial ICND2110 pins into the clk domain and flags each clock_in
// rising edge as a one-cycle bit_valid; also watches for a stalled link.
module icnd2110_bit_sampler #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  input  logic clock_in,
  input  logic busy,
  output logic bit_valid,
  output logic bit_data,
  output logic timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    data_sync;
  logic [2:0]    clk_sync;
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_sync <= '0;
      clk_sync  <= '0;
    end else begin
      data_sync <= {data_sync[0], data_in};
      clk_sync  <= {clk_sync[1:0], clock_in};
    end
  end

  // Data is launched on the falling edge, so it is long settled when the
  // synchronised rising edge is seen; both paths share the same latency.
  assign bit_valid = clk_sync[1] & ~clk_sync[2];
  assign bit_data  = data_sync[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!busy || bit_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        idle_cnt <= '0;
        timeout  <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/icnd2110_in.sv
// ICND2110 serial receiver: finds the 128-ones preamble, captures the register
// word, and turns each 96-bit group into six addressed memory writes.
module icnd2110_in
  import icnd2110_defs::*;
#(
  parameter int START_ADDRESS     = 0,
  parameter int WORD_COUNT        = 336,
  parameter int ADDRESS_BUS_WIDTH = 12,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_in,
  input  logic                         clock_in,
  output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  output logic [15:0]                  write_data,
  output logic                         write_strobe,
  output logic [15:0]                  config_word,
  output logic                         config_strobe,
  output logic                         frame_done_strobe,
  output logic                         frame_error_strobe,
  output logic                         busy
);

  localparam int     AW         = ADDRESS_BUS_WIDTH;
  localparam longint ADDR_LIMIT = longint'(START_ADDRESS) + longint'(WORD_COUNT);

  state_t               state, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [RUN_W-1:0]     run, run_d;
  logic [IDX_W-1:0]     commit_idx, commit_idx_d;
  logic [AW-1:0]        group_base, group_base_d;
  logic                 seen_reg, seen_reg_d;
  logic                 all_ones, all_ones_d;

  logic                  bit_valid, bit_data, timeout;
  logic                  shift_en, cfg_load, wr_fire, done_ev, err_ev;
  logic [GROUP_BITS-1:0] staging;
  logic [AW-1:0]         wr_addr;
  logic                  in_range;

  icnd2110_bit_sampler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .clock_in (clock_in),
    .busy     (busy),
    .bit_valid(bit_valid),
    .bit_data (bit_data),
    .timeout  (timeout)
  );

  assign busy = (state != ST_HUNT);

  // Wire order within a group is out5..out0, so word k lands at base + 5 - k.
  assign wr_addr  = group_base + AW'(WORDS_PER_GROUP - 1) - AW'(commit_idx);
  assign in_range = (longint'(wr_addr) < ADDR_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_HUNT;
      bit_cnt    <= '0;
      run        <= '0;
      commit_idx <= '0;
      group_base <= '0;
      seen_reg   <= 1'b0;
      all_ones   <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      run        <= run_d;
      commit_idx <= commit_idx_d;
      group_base <= group_base_d;
      seen_reg   <= seen_reg_d;
      all_ones   <= all_ones_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    run_d        = run;
    commit_idx_d = commit_idx;
    group_base_d = group_base;
    seen_reg_d   = seen_reg;
    all_ones_d   = all_ones;
    shift_en     = 1'b0;
    cfg_load     = 1'b0;
    wr_fire      = 1'b0;
    done_ev      = 1'b0;
    err_ev       = 1'b0;

    if (timeout && state != ST_HUNT) begin
      err_ev  = 1'b1;
      state_d = ST_HUNT;
      run_d   = '0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (bit_valid) begin
            if (bit_data) begin
              run_d = run_inc(run);
            end else begin
              // The terminating 0 is already the first blank bit.
              if (run == RUN_W'(START_ONES)) begin
                state_d      = ST_BLANK;
                bit_cnt_d    = BIT_CNT_W'(1);
                seen_reg_d   = 1'b0;
                group_base_d = AW'(START_ADDRESS);
              end
              run_d = '0;
            end
          end
        end

        ST_BLANK: begin
          if (bit_valid) begin
            if (bit_data) begin
              err_ev  = 1'b1;
              state_d = ST_HUNT;
              run_d   = '0;
            end else if (bit_cnt == BIT_CNT_W'(BLANK_BITS - 1)) begin
              bit_cnt_d  = '0;
              all_ones_d = 1'b1;
              state_d    = seen_reg ? ST_GROUP : ST_REG;
            end else begin
              bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        ST_REG: begin
          if (bit_valid) begin
            shift_en = 1'b1;
            if (bit_cnt == BIT_CNT_W'(WORD_BITS - 1)) begin
              cfg_load   = 1'b1;
              seen_reg_d = 1'b1;
              bit_cnt_d  = '0;
              state_d    = ST_BLANK;
            end else begin
              bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        ST_GROUP: begin
          if (bit_valid) begin
            if (bit_cnt == BIT_CNT_W'(GROUP_BITS)) begin
              if (!bit_data) begin
                state_d      = ST_COMMIT;
                commit_idx_d = '0;
                bit_cnt_d    = BIT_CNT_W'(1);
              end else begin
                state_d = ST_HUNT;
                run_d   = '0;
                done_ev = all_ones;
                err_ev  = !all_ones;
              end
            end else begin
              shift_en   = 1'b1;
              all_ones_d = all_ones & bit_data;
              bit_cnt_d  = bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        ST_COMMIT: begin
          wr_fire = 1'b1;
          if (commit_idx == IDX_W'(WORDS_PER_GROUP - 1)) begin
            state_d      = ST_BLANK;
            group_base_d = group_base + AW'(WORDS_PER_GROUP);
          end else begin
            commit_idx_d = commit_idx + IDX_W'(1);
          end
        end

        default: begin
          state_d = ST_HUNT;
          run_d   = '0;
        end
      endcase
    end
  end

  // NOTE: the staging buffer is pure datapath and is never read before it has
  // been completely refilled, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      staging <= {staging[GROUP_BITS-2:0], bit_data};
    end else if (state == ST_COMMIT) begin
      staging <= {staging[GROUP_BITS-WORD_BITS-1:0], {WORD_BITS{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      write_address      <= '0;
      write_data         <= '0;
      write_strobe       <= 1'b0;
      config_word        <= '0;
      config_strobe      <= 1'b0;
      frame_done_strobe  <= 1'b0;
      frame_error_strobe <= 1'b0;
    end else begin
      write_strobe       <= wr_fire && in_range;
      config_strobe      <= cfg_load;
      frame_done_strobe  <= done_ev;
      frame_error_strobe <= err_ev;
      if (wr_fire && in_range) begin
        write_address <= wr_addr;
        write_data    <= staging[GROUP_BITS-1 -: WORD_BITS];
      end
      if (cfg_load) begin
        config_word <= {staging[WORD_BITS-2:0], bit_data};
      end
    end
  end

endmodule
